ram_burst_reader: RTL and testbench



---
 rtl/ram_pkg.sv | 12 +
 rtl/ram_rd_skid_buf.sv | 65 ++++++
 rtl/ram_burst_reader.sv | 126 ++++++++++++
 tb/tb_ram_burst_reader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and constants for the RAM burst read path.
package ram_pkg;

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   localparam int OUT_DEPTH = 2;

   function automatic int ram_depth(input int aw);
      return 2 ** aw;
   endfunction

endpackage

// File: rtl/ram_rd_skid_buf.sv
// Two-entry {last, data} FIFO with registered head outputs, absorbing RAM read
// latency and consumer backpressure.
module ram_rd_skid_buf import ram_pkg::*; #(
   parameter int dataWidth = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic [dataWidth-1:0] push_data,
   input  logic                 push_last,
   input  logic                 pop,
   output logic                 valid,
   output logic [dataWidth-1:0] data,
   output logic                 last,
   output logic [1:0]           count
);

   logic [dataWidth:0] head_reg;
   logic [dataWidth:0] tail_reg;
   logic [1:0]         count_reg;
   logic [dataWidth:0] entry;
   logic               pop_ok;
   logic               push_ok;

   assign entry   = {push_last, push_data};
   assign pop_ok  = pop && (count_reg != 2'd0);
   assign push_ok = push && ((count_reg < 2'(OUT_DEPTH)) || pop_ok);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (count_reg == 2'd0)
                  head_reg <= entry;
               else
                  tail_reg <= entry;
               count_reg <= count_reg + 2'd1;
            end
            2'b01: begin
               head_reg  <= tail_reg;
               count_reg <= count_reg - 2'd1;
            end
            2'b11: begin
               // Simultaneous push/pop: occupancy unchanged, order preserved.
               if (count_reg == 2'd1) begin
                  head_reg <= entry;
               end else begin
                  head_reg <= tail_reg;
                  tail_reg <= entry;
               end
            end
            default: ;
         endcase
      end
   end

   assign valid        = (count_reg != 2'd0);
   assign {last, data} = head_reg;
   assign count        = count_reg;

endmodule

// File: rtl/ram_burst_reader.sv
// Issues a burst of sequential reads to a synchronous-read RAM and streams the
// returned words out over valid/ready, throttled by output buffer credit.
module ram_burst_reader import ram_pkg::*; #(
   parameter int addressWidth = 5,
   parameter int dataWidth    = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [addressWidth-1:0] start_addr,
   input  logic [addressWidth:0]   len,
   output logic                    busy,
   output logic                    done,
   output logic                    ram_en,
   output logic [addressWidth-1:0] ram_address,
   input  logic [dataWidth-1:0]    ram_dout,
   output logic                    m_valid,
   output logic [dataWidth-1:0]    m_data,
   output logic                    m_last,
   input  logic                    m_ready
);

   localparam int DEPTH = ram_depth(addressWidth);
   localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(DEPTH - 1);

   state_t                  state_reg;
   logic [addressWidth-1:0] ptr_reg;
   logic [addressWidth:0]   issue_cnt_reg;
   logic [addressWidth:0]   accept_cnt_reg;
   logic                    inflight_reg;
   logic                    inflight_last_reg;
   logic                    busy_reg;
   logic                    done_reg;

   logic                    pop;
   logic                    issue;
   logic [1:0]              occ;
   logic [1:0]              occ_after;
   logic [2:0]              credit;
   logic [addressWidth:0]   issue_next;
   logic [addressWidth:0]   accept_next;
   logic [addressWidth-1:0] ptr_next;

   ram_rd_skid_buf #(.dataWidth(dataWidth)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_reg),
      .push_data (ram_dout),
      .push_last (inflight_last_reg),
      .pop       (pop),
      .valid     (m_valid),
      .data      (m_data),
      .last      (m_last),
      .count     (occ)
   );

   // Credit counts words already buffered (after this cycle's pop) plus the
   // read still in flight, so every issued read has a guaranteed slot.
   assign pop         = m_valid && m_ready;
   assign occ_after   = occ - {1'b0, pop};
   assign credit      = {1'b0, occ_after} + {2'b00, inflight_reg};
   assign issue       = (state_reg == READ) && (issue_cnt_reg != '0) &&
                        (credit < 3'(OUT_DEPTH));
   assign issue_next  = issue_cnt_reg - {{addressWidth{1'b0}}, issue};
   assign accept_next = accept_cnt_reg - {{addressWidth{1'b0}}, pop};
   assign ptr_next    = (ptr_reg == LAST_ADDR) ? '0 : ptr_reg + 1'b1;

   assign ram_en      = issue;
   assign ram_address = ptr_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg         <= IDLE;
         ptr_reg           <= '0;
         issue_cnt_reg     <= '0;
         accept_cnt_reg    <= '0;
         inflight_reg      <= 1'b0;
         inflight_last_reg <= 1'b0;
         busy_reg          <= 1'b0;
         done_reg          <= 1'b0;
      end else begin
         inflight_reg      <= issue;
         inflight_last_reg <= issue && (issue_cnt_reg == {{addressWidth{1'b0}}, 1'b1});
         case (state_reg)
            IDLE: begin
               if (start) begin
                  busy_reg <= 1'b1;
                  if (len != '0) begin
                     state_reg      <= READ;
                     ptr_reg        <= start_addr;
                     issue_cnt_reg  <= len;
                     accept_cnt_reg <= len;
                  end else begin
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                  end
               end
            end
            READ: begin
               issue_cnt_reg  <= issue_next;
               accept_cnt_reg <= accept_next;
               if (issue)
                  ptr_reg <= ptr_next;
               if (issue_next == '0)
                  state_reg <= DRAIN;
            end
            DRAIN: begin
               accept_cnt_reg <= accept_next;
               if (accept_next == '0) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader: RAM model, beat monitor and assertions.
module tb_ram_burst_reader;

   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [AW:0]   len = '0;
   logic          busy;
   logic          done;
   logic          ram_en;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_dout = '0;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          m_ready = 1'b0;

   ram_burst_reader #(.addressWidth(AW), .dataWidth(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .start_addr  (start_addr),
      .len         (len),
      .busy        (busy),
      .done        (done),
      .ram_en      (ram_en),
      .ram_address (ram_address),
      .ram_dout    (ram_dout),
      .m_valid     (m_valid),
      .m_data      (m_data),
      .m_last      (m_last),
      .m_ready     (m_ready)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [0:31];
   always @(posedge clk) if (ram_en) ram_dout <= mem[ram_address];

   int checks = 0;
   int errors = 0;

   logic [DW:0]   beats[$];
   logic [AW-1:0] addrs[$];
   int            done_cnt = 0;
   int            stall_viol = 0;
   int            credit_viol = 0;
   int            issued = 0;
   int            accepted = 0;
   logic          stalled_prev = 1'b0;
   logic [DW:0]   prev_word = '0;

   // Samples mid-cycle; each observed handshake completes on the next edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         issued = 0;
         accepted = 0;
         stalled_prev = 1'b0;
      end else begin
         if (stalled_prev && !(m_valid && ({m_last, m_data} === prev_word))) stall_viol++;
         if (ram_en && ((issued - accepted - ((m_valid && m_ready) ? 1 : 0)) >= 2)) credit_viol++;
         if (ram_en) begin
            issued++;
            addrs.push_back(ram_address);
         end
         if (m_valid && m_ready) begin
            accepted++;
            beats.push_back({m_last, m_data});
         end
         if (done) done_cnt++;
         stalled_prev = m_valid && !m_ready;
         prev_word = {m_last, m_data};
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start(input logic [AW-1:0] a, input logic [AW:0] l);
      start_addr = a;
      len = l;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int base, input int bound, input string tag);
      int n = 0;
      while (done_cnt == base && n < bound) begin
         step();
         n++;
      end
      chk({tag, "_timeout"}, 64'(done_cnt > base), 64'd1);
   endtask

   // start_addr=3, len=4, m_ready=1, checked cycle by cycle.
   task automatic burst_a(input string tag);
      int db = done_cnt;
      m_ready = 1'b1;
      pulse_start(5'd3, 6'd4);
      chk({tag, "_k0_busy"}, 64'(busy), 64'd1);
      chk({tag, "_k0_ram_en"}, 64'(ram_en), 64'd1);
      chk({tag, "_k0_addr"}, 64'(ram_address), 64'd3);
      chk({tag, "_k0_valid"}, 64'(m_valid), 64'd0);
      step();
      chk({tag, "_k1_valid"}, 64'(m_valid), 64'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk({tag, "_beat_valid"}, 64'(m_valid), 64'd1);
         chk({tag, "_beat_data"}, 64'(m_data), 64'(32'h103 + i));
         chk({tag, "_beat_last"}, 64'(m_last), 64'(i == 3));
      end
      step();
      chk({tag, "_done_pulse"}, 64'({done, busy, m_valid}), 64'b110);
      step();
      chk({tag, "_after_done"}, 64'({done, busy}), 64'b00);
      chk({tag, "_done_count"}, 64'(done_cnt - db), 64'd1);
   endtask

   initial begin
      int ab, bb, db, sv, cv, n;
      logic [DW:0] exp_word;

      for (int i = 0; i < 32; i++) mem[i] = 32'h100 + i;

      // Reset state
      repeat (3) step();
      chk("rst_ctrl", 64'({busy, done, ram_en, m_valid, m_last}), 64'd0);
      chk("rst_addr", 64'(ram_address), 64'd0);
      chk("rst_data", 64'(m_data), 64'd0);
      rst_n = 1'b1;
      step();

      // Basic burst
      burst_a("s1");

      // Wrap-around
      ab = addrs.size(); bb = beats.size(); db = done_cnt;
      pulse_start(5'd30, 6'd4);
      wait_done(db, 50, "s2");
      chk("s2_nbeats", 64'(beats.size() - bb), 64'd4);
      for (int i = 0; i < 4; i++) begin
         exp_word = {(i == 3), 32'h100 + 32'((30 + i) % 32)};
         chk("s2_addr", 64'(addrs[ab + i]), 64'((30 + i) % 32));
         chk("s2_word", 64'(beats[bb + i]), 64'(exp_word));
      end

      // Backpressure with m_ready pattern 1,0,0,1
      ab = addrs.size(); bb = beats.size(); db = done_cnt; sv = stall_viol; cv = credit_viol;
      m_ready = 1'b1;
      pulse_start(5'd10, 6'd8);
      n = 0;
      while (done_cnt == db && n < 200) begin
         m_ready = ((n % 4) == 0) || ((n % 4) == 3);
         step();
         n++;
      end
      m_ready = 1'b1;
      chk("s3_timeout", 64'(done_cnt > db), 64'd1);
      chk("s3_nbeats", 64'(beats.size() - bb), 64'd8);
      for (int i = 0; i < 8; i++) begin
         exp_word = {(i == 7), 32'h10A + 32'(i)};
         chk("s3_word", 64'(beats[bb + i]), 64'(exp_word));
      end
      chk("s3_stall_stable", 64'(stall_viol - sv), 64'd0);
      chk("s3_credit", 64'(credit_viol - cv), 64'd0);
      chk("s3_nreads", 64'(addrs.size() - ab), 64'd8);

      // Zero-length burst
      ab = addrs.size(); bb = beats.size(); db = done_cnt;
      pulse_start(5'd7, 6'd0);
      chk("s4_zero_k0", 64'({done, busy, ram_en, m_valid}), 64'b1100);
      step();
      chk("s4_zero_k1", 64'({done, busy}), 64'b00);
      chk("s4_zero_reads", 64'(addrs.size() - ab), 64'd0);
      chk("s4_zero_beats", 64'(beats.size() - bb), 64'd0);
      chk("s4_zero_done", 64'(done_cnt - db), 64'd1);

      // Start while busy is ignored
      ab = addrs.size(); bb = beats.size(); db = done_cnt;
      pulse_start(5'd0, 6'd4);
      start_addr = 5'd20;
      len = 6'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done(db, 50, "s4_busy");
      chk("s4_busy_nbeats", 64'(beats.size() - bb), 64'd4);
      chk("s4_busy_nreads", 64'(addrs.size() - ab), 64'd4);
      for (int i = 0; i < 4; i++) begin
         exp_word = {(i == 3), 32'h100 + 32'(i)};
         chk("s4_busy_word", 64'(beats[bb + i]), 64'(exp_word));
      end
      repeat (3) step();
      chk("s4_busy_idle", 64'({busy, done, ram_en}), 64'd0);
      chk("s4_busy_done", 64'(done_cnt - db), 64'd1);

      // Reset mid-burst
      bb = beats.size(); db = done_cnt;
      pulse_start(5'd0, 6'd8);
      n = 0;
      while ((beats.size() - bb) < 3 && n < 50) begin
         step();
         n++;
      end
      chk("s5_progress", 64'((beats.size() - bb) >= 3), 64'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("s5_rst_ctrl", 64'({busy, done, ram_en, m_valid, m_last}), 64'd0);
      chk("s5_rst_addr", 64'(ram_address), 64'd0);
      chk("s5_rst_data", 64'(m_data), 64'd0);
      repeat (12) step();
      chk("s5_no_done", 64'(done_cnt - db), 64'd0);
      chk("s5_quiet", 64'({busy, m_valid}), 64'd0);
      burst_a("s5");

      // Full-depth burst from 5
      ab = addrs.size(); bb = beats.size(); db = done_cnt; cv = credit_viol;
      pulse_start(5'd5, 6'd32);
      wait_done(db, 100, "s6");
      chk("s6_nbeats", 64'(beats.size() - bb), 64'd32);
      chk("s6_nreads", 64'(addrs.size() - ab), 64'd32);
      for (int i = 0; i < 32; i++) begin
         exp_word = {(i == 31), 32'h100 + 32'((5 + i) % 32)};
         chk("s6_addr", 64'(addrs[ab + i]), 64'((5 + i) % 32));
         chk("s6_word", 64'(beats[bb + i]), 64'(exp_word));
      end
      chk("s6_credit", 64'(credit_viol - cv), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
